// File: rtl/calc_axil_slave.sv
// calc_axil_slave: AXI4-Lite register slave wrapping a one-cycle ALU.
// OPA/OPB/CTRL/CMD are host registers; a CMD start runs IDLE/EXEC/DONE.
module calc_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            calc_done
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_e;

    logic          aw_full_q;
    logic [2:0]    aw_idx_q;
    logic          w_full_q;
    logic [DW-1:0] w_data_q;
    logic [DW/8-1:0] w_strb_q;
    logic          bvalid_q;
    logic [1:0]    bresp_q;

    logic          rvalid_q;
    logic [DW-1:0] rdata_q;
    logic [1:0]    rresp_q;

    logic [DW-1:0] opa_q;
    logic [DW-1:0] opb_q;
    logic [DW-1:0] ctrl_q;
    logic [DW-1:0] cmd_q;
    logic [DW-1:0] result_q;
    logic          busy_q;
    logic          done_q;
    state_e        state_q;

    logic          aw_hs;
    logic          w_hs;
    logic          ar_hs;
    logic          commit;
    logic          start;
    logic [DW-1:0] rd_data_d;
    logic [1:0]    rd_resp_d;
    logic [DW-1:0] result_d;
    logic          unused_ok;

    function automatic logic [DW-1:0] merge(
        input logic [DW-1:0]   old_v,
        input logic [DW-1:0]   new_v,
        input logic [DW/8-1:0] strb
    );
        logic [DW-1:0] r;
        r = old_v;
        for (int i = 0; i < DW/8; i++)
            if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        return r;
    endfunction

    // Ready lines are held low while reset is applied.
    assign S_AXI_AWREADY = ~aw_full_q & ~S_AXI_ARESET;
    assign S_AXI_WREADY  = ~w_full_q & ~S_AXI_ARESET;
    assign S_AXI_ARREADY = (~rvalid_q | S_AXI_RREADY) & ~S_AXI_ARESET;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit = aw_full_q & w_full_q & ~bvalid_q;
    assign start  = commit & (aw_idx_q == 3'd3) & w_strb_q[0] & w_data_q[0];

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;
    assign calc_done    = done_q;

    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_idx_q  <= S_AXI_AWADDR[AW-1:2];
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (aw_idx_q[2:1] == 2'b11) ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q  <= 1'b0;
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            opa_q  <= '0;
            opb_q  <= '0;
            ctrl_q <= '0;
            cmd_q  <= '0;
        end else if (commit) begin
            case (aw_idx_q)
                3'd0:    opa_q  <= merge(opa_q, w_data_q, w_strb_q);
                3'd1:    opb_q  <= merge(opb_q, w_data_q, w_strb_q);
                3'd2:    ctrl_q <= merge(ctrl_q, w_data_q, w_strb_q);
                3'd3:    cmd_q  <= merge(cmd_q, w_data_q, w_strb_q);
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RESP_OKAY;
        case (S_AXI_ARADDR[AW-1:2])
            3'd0:    rd_data_d = opa_q;
            3'd1:    rd_data_d = opb_q;
            3'd2:    rd_data_d = ctrl_q;
            3'd3:    rd_data_d = cmd_q;
            3'd4:    rd_data_d = result_q;
            3'd5:    rd_data_d = {{(DW-2){1'b0}}, done_q, busy_q};
            default: rd_resp_d = RESP_SLVERR;
        endcase
    end

    // Read data comes from the _q registers, so a same-cycle write is not seen.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_d;
            rresp_q  <= rd_resp_d;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    always_comb begin
        result_d = '0;
        case (ctrl_q[1:0])
            2'b00:   result_d = opa_q + opb_q;
            2'b01:   result_d = opa_q - opb_q;
            2'b10:   result_d = opa_q * opb_q;
            default: result_d = opa_q & opb_q;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_EXEC: begin
                    state_q  <= S_DONE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    result_q <= result_d;
                end
                default: begin
                    if (start) begin
                        state_q <= S_EXEC;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_axil_slave.sv
// Directed bench for calc_axil_slave: register access, calc results,
// handshake timing, error responses and reset abort.
module tb_calc_axil_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [4:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        calc_done;

    int vectors = 0;
    int miscompares = 0;
    int n;
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [1:0]  rr;

    always #5 clk = ~clk;

    calc_axil_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .calc_done     (calc_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] r);
        int k;
        logic ah, wh;
        @(negedge clk);
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        bready = 1'b1;
        k = 0;
        while ((awvalid || wvalid) && k < 20) begin
            ah = awvalid & awready;
            wh = wvalid & wready;
            @(negedge clk);
            k++;
            if (ah) awvalid = 1'b0;
            if (wh) wvalid = 1'b0;
        end
        if (awvalid || wvalid) begin
            tmo("wr_addr_data");
            awvalid = 1'b0;
            wvalid = 1'b0;
        end
        k = 0;
        while (!bvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bvalid) begin
            tmo("wr_bvalid");
            r = 2'bxx;
        end else begin
            r = bresp;
        end
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d,
                            output logic [1:0] r);
        int k;
        logic ah;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        k = 0;
        while (arvalid && k < 20) begin
            ah = arready;
            @(negedge clk);
            k++;
            if (ah) arvalid = 1'b0;
        end
        if (arvalid) begin
            tmo("rd_addr");
            arvalid = 1'b0;
        end
        k = 0;
        while (!rvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!rvalid) begin
            tmo("rd_rvalid");
            d = 'x;
            r = 2'bxx;
        end else begin
            d = rdata;
            r = rresp;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_awready", 32'(awready), 0);
        chk("rst_wready", 32'(wready), 0);
        chk("rst_arready", 32'(arready), 0);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_done", 32'(calc_done), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_awready", 32'(awready), 1);
        chk("post_wready", 32'(wready), 1);
        chk("post_arready", 32'(arready), 1);

        // Basic write/readback of the rw registers
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(i * 4), 32'(i + 1), 4'hF, resp);
            chk("wr_bresp", 32'(resp), 0);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(i * 4), rd, rr);
            chk("rd_data", rd, 32'(i + 1));
            chk("rd_rresp", 32'(rr), 0);
        end

        // 7 - 5, observing busy then done
        axi_write(5'h00, 32'd7, 4'hF, resp);
        axi_write(5'h04, 32'd5, 4'hF, resp);
        axi_write(5'h08, 32'd1, 4'hF, resp);
        @(negedge clk);
        awaddr = 5'h0C; awvalid = 1'b1;
        wdata = 32'd1; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("cmd_bvalid", 32'(bvalid), 1);
        chk("exec_done_low", 32'(calc_done), 0);
        araddr = 5'h14; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk("exec_status_rvalid", 32'(rvalid), 1);
        chk("exec_status_busy", rdata, 1);
        chk("done_high", 32'(calc_done), 1);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("cmd_b_cleared", 32'(bvalid), 0);
        axi_read(5'h14, rd, rr);
        chk("status_done", rd, 2);
        axi_read(5'h10, rd, rr);
        chk("result_sub", rd, 2);

        // Wrap-around add, truncated multiply, and
        axi_write(5'h00, 32'hFFFF_FFFF, 4'hF, resp);
        axi_write(5'h04, 32'd2, 4'hF, resp);
        axi_write(5'h08, 32'd0, 4'hF, resp);
        axi_write(5'h0C, 32'd1, 4'hF, resp);
        axi_read(5'h10, rd, rr);
        chk("result_add_wrap", rd, 32'd1);
        axi_write(5'h08, 32'd2, 4'hF, resp);
        axi_write(5'h0C, 32'd1, 4'hF, resp);
        axi_read(5'h10, rd, rr);
        chk("result_mul", rd, 32'hFFFF_FFFE);
        axi_write(5'h08, 32'd3, 4'hF, resp);
        axi_write(5'h0C, 32'd1, 4'hF, resp);
        axi_read(5'h10, rd, rr);
        chk("result_and", rd, 32'd2);

        // Read-only and unmapped words
        axi_write(5'h10, 32'h1234_5678, 4'hF, resp);
        chk("ro_bresp", 32'(resp), 0);
        axi_read(5'h10, rd, rr);
        chk("ro_unchanged", rd, 32'd2);
        axi_write(5'h18, 32'h1234_5678, 4'hF, resp);
        chk("unmapped_bresp", 32'(resp), 2);
        axi_read(5'h18, rd, rr);
        chk("unmapped_rdata", rd, 0);
        chk("unmapped_rresp", 32'(rr), 2);
        axi_read(5'h1C, rd, rr);
        chk("unmapped7_rresp", 32'(rr), 2);

        // Read in the commit cycle returns the old value
        @(negedge clk);
        awaddr = 5'h04; awvalid = 1'b1;
        wdata = 32'h0000_DEAD; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 5'h04; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk("raw_rvalid", 32'(rvalid), 1);
        chk("raw_old", rdata, 32'd2);
        chk("raw_bvalid", 32'(bvalid), 1);
        @(negedge clk);
        bready = 1'b0;
        axi_read(5'h04, rd, rr);
        chk("raw_new", rd, 32'h0000_DEAD);

        // W ahead of AW, held B, byte-lane write
        axi_write(5'h00, 32'h1122_3344, 4'hF, resp);
        @(negedge clk);
        wdata = 32'hAABB_CCDD; wstrb = 4'b0010; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
        chk("w_latched", 32'(wready), 0);
        chk("no_b_without_aw", 32'(bvalid), 0);
        @(negedge clk);
        @(negedge clk);
        awaddr = 5'h00; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid) tmo("late_aw_bvalid");
        for (int i = 0; i < 4; i++) begin
            chk("bvalid_hold", 32'(bvalid), 1);
            chk("bresp_hold", 32'(bresp), 0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("single_b_1", 32'(bvalid), 0);
        @(negedge clk);
        chk("single_b_2", 32'(bvalid), 0);
        chk("aw_free", 32'(awready), 1);
        axi_read(5'h00, rd, rr);
        chk("partial_write", rd, 32'h1122_CC44);

        // Reset during EXEC with R and B beats pending
        rready = 1'b0;
        @(negedge clk);
        araddr = 5'h00; arvalid = 1'b1;
        awaddr = 5'h0C; awvalid = 1'b1;
        wdata = 32'd1; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("pend_rvalid", 32'(rvalid), 1);
        @(negedge clk);
        chk("pend_rvalid_hold", 32'(rvalid), 1);
        chk("pend_bvalid", 32'(bvalid), 1);
        chk("pend_exec", 32'(calc_done), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rvalid", 32'(rvalid), 0);
        chk("abort_bvalid", 32'(bvalid), 0);
        chk("abort_done", 32'(calc_done), 0);
        chk("abort_rdata", rdata, 0);
        chk("abort_awready", 32'(awready), 0);
        rst = 1'b0;
        rready = 1'b1;
        axi_read(5'h14, rd, rr);
        chk("abort_status", rd, 0);
        axi_read(5'h00, rd, rr);
        chk("abort_opa", rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
